instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the control unit. It holds a program in a small instruction memory, steps a program counter, and drives the CU's `instr` input. Each word is held stable for exactly as many cycles as the CU needs to finish that instruction type. No handshake with the CU is needed: the hold count is derived from the instruction-type field in bits [19:18].

## Interface
- INSTR_WIDTH, 20, instruction word width; type field is bits [19:18].
- ADDR_BITS, 5, instruction memory address width (2^ADDR_BITS words).
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- prog_we  in  1  instruction memory write enable.
- prog_addr  in  ADDR_BITS  write address.
- prog_data  in  INSTR_WIDTH  write data.
- start  in  1  begin execution at address 0; sampled only in IDLE.
- instr  out  INSTR_WIDTH  registered instruction to the CU.
- pc  out  ADDR_BITS  address of the word currently on `instr`.
- running  out  1  high while in ISSUE.
- halted  out  1  high in HALT.

## Operation
- Memory: 2^ADDR_BITS x INSTR_WIDTH, synchronous write, not cleared by rst (program survives reset).
- Writes are accepted in every state.
- A read and a write to the same address in the same cycle returns the old data.
- States: IDLE, ISSUE, HALT. Any unused encoding goes to IDLE.
- IDLE, start=1: load instr<=mem[0], pc<=0, first<=1, then go to ISSUE (or HALT if mem[0][19:18]=00).
- Hold count N by type of the presented word:
  - 01 (std_op): N=3 (CU decode, execute, write-back).
  - 10 (loadR): N=4 (decode, execute, mem-access, write-back).
  - 11 (storeR): N=3 (decode, execute, mem-access).
- First word after start is held N+1 cycles: the extra cycle lets the CU leave its reset state.
- ISSUE: cnt is loaded with (hold - 1) when a word is presented and decrements each cycle. When cnt=0, the next edge loads instr<=mem[pc+1], pc<=pc+1 and reloads cnt from the new word's type.
- Halt word: type 00. On loading it, go to HALT with running=0 and halted=1. pc and instr freeze on the halt word. Only rst leaves HALT.
- PC arithmetic is ADDR_BITS-wide modulo: pc=2^ADDR_BITS-1 wraps to 0 and execution continues.
- start in ISSUE or HALT is ignored.
- cnt is 3 bits wide.

## Timing
- Reset values (asynchronous, immediate): instr=0, pc=0, cnt=0, state IDLE, running=0, halted=0.
  - instr=0 has type 00, which holds the CU in its reset state.
- start sampled at edge E0: instr=mem[0], pc=0 and running=1 are visible after E0 (1-cycle latency).
- The word loaded at edge Ek changes at Ek+N, or Ek+N+1 for the first word.
- Change points for a program std, load, store, halt with start at E0: E0, E4, E8, E11.
- halted rises and running falls at the same edge that loads the halt word.
- rst asserted mid-instruction aborts immediately. Deassertion returns to IDLE and requires a new start.

## Test plan
- Reset: rst=1 at any point -> instr=20'h0, pc=0, running=0, halted=0 with no clock edge. Memory contents are unchanged afterwards (read back via a run).
- Sequence: program mem[0]=20'h51230 (std), mem[1]=20'h90050 (loadR), mem[2]=20'hD0070 (storeR), mem[3]=20'h00000, then pulse start -> instr changes at E0/E4/E8/E11, pc=0/1/2/3, halted=1 from E11 onward, and instr stays 20'h00000.
- Wrap: ADDR_BITS=2, all four words std_op with no halt -> pc sequence 0,1,2,3,0,1 with each word held 3 cycles (first 4).
- Abort: assert rst 2 cycles into the loadR word -> outputs return to reset values immediately. After deassert, instr stays 0 until start. A restart replays from mem[0] with identical timing.
- Start ignored and live write: pulse start during ISSUE -> pc and timing unaffected. Write mem[3]=20'h51000 while executing mem[1] -> the new word is fetched at its slot.
- Same-address collision: write mem[k] on the same edge it is fetched -> the old word appears on instr.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program memory plus a PC that presents each word to the
// control unit for as many cycles as that instruction type needs.
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [ADDR_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   running,
    output logic                   halted
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d;
    logic [2:0]             cnt_q, cnt_d;

    logic [ADDR_BITS-1:0]   pc_next;
    logic [INSTR_WIDTH-1:0] word_first;
    logic [INSTR_WIDTH-1:0] word_next;
    logic [1:0]             type_first;
    logic [1:0]             type_next;

    // Cycles the CU spends on each instruction type; type 00 is the halt word.
    function automatic logic [2:0] hold_of(input logic [1:0] typ);
        case (typ)
            2'b01:   hold_of = 3'd3;
            2'b10:   hold_of = 3'd4;
            2'b11:   hold_of = 3'd3;
            default: hold_of = 3'd0;
        endcase
    endfunction

    // The program has no reset so it survives rst; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign pc_next    = pc_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    assign word_first = mem_q[{ADDR_BITS{1'b0}}];
    assign word_next  = mem_q[pc_next];
    assign type_first = word_first[INSTR_WIDTH-1 -: 2];
    assign type_next  = word_next[INSTR_WIDTH-1 -: 2];

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d = word_first;
                    pc_d    = {ADDR_BITS{1'b0}};
                    // Loading hold rather than hold-1 gives the first word its extra cycle.
                    if (type_first == 2'b00) begin
                        state_d = S_HALT;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = S_ISSUE;
                        cnt_d   = hold_of(type_first);
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == 3'd0) begin
                    instr_d = word_next;
                    pc_d    = pc_next;
                    if (type_next == 2'b00) begin
                        state_d = S_HALT;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d   = hold_of(type_next) - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr   = instr_q;
    assign pc      = pc_q;
    assign running = (state_q == S_ISSUE);
    assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a duration-based program model plus
// directed scenarios and a randomized run, and a 2-bit-address instance for wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic        start = 1'b0;
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        running;
    logic        halted;

    logic        w_we = 1'b0;
    logic [1:0]  w_addr = '0;
    logic [19:0] w_data = '0;
    logic        w_start = 1'b0;
    logic [19:0] w_instr;
    logic [1:0]  w_pc;
    logic        w_running;
    logic        w_halted;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.INSTR_WIDTH(20), .ADDR_BITS(5)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .instr(instr), .pc(pc),
        .running(running), .halted(halted)
    );

    instr_fetch #(.INSTR_WIDTH(20), .ADDR_BITS(2)) dut_w (
        .clk(clk), .rst(rst), .prog_we(w_we), .prog_addr(w_addr),
        .prog_data(w_data), .start(w_start), .instr(w_instr), .pc(w_pc),
        .running(w_running), .halted(w_halted)
    );

    always #5 clk = ~clk;

    logic [26:0] obs;
    assign obs = {instr, pc, running, halted};

    // Reference model: each word is shown for a number of cycles set by its type.
    logic [19:0] m_mem [32];
    int          m_state;   // 0 idle, 1 running, 2 halted
    logic [19:0] m_instr;
    logic [4:0]  m_pc;
    int          m_shown;
    int          m_need;

    function automatic int cycles_for(input logic [19:0] w);
        return (w[19:18] == 2'b10) ? 4 : 3;
    endfunction

    function automatic void m_present(input logic [4:0] a, input int first);
        m_pc    = a;
        m_instr = m_mem[a];
        m_shown = 0;
        if (m_instr[19:18] == 2'b00) m_state = 2;
        else begin
            m_state = 1;
            m_need  = cycles_for(m_instr) + first;
        end
    endfunction

    function automatic void m_reset();
        m_state = 0;
        m_instr = '0;
        m_pc    = '0;
        m_shown = 0;
        m_need  = 0;
    endfunction

    function automatic void m_edge(input logic we, input logic [4:0] a,
                                   input logic [19:0] d, input logic st);
        if (m_state == 0 && st) m_present(5'd0, 1);
        else if (m_state == 1) begin
            m_shown++;
            if (m_shown == m_need) m_present(m_pc + 5'd1, 0);
        end
        if (we) m_mem[a] = d;
    endfunction

    function automatic logic [26:0] m_exp();
        return {m_instr, m_pc, m_state == 1, m_state == 2};
    endfunction

    task automatic step(input logic we, input logic [4:0] a, input logic [19:0] d, input logic st);
        prog_we = we; prog_addr = a; prog_data = d; start = st;
        @(posedge clk);
        m_edge(we, a, d, st);
        #1;
        prog_we = 1'b0; start = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if (obs !== 27'h0) begin
            errors++;
            $display("FAIL reset_initial got=%h want=%h", obs, 27'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 32; k++) step(1'b1, 5'(k), 20'h0, 1'b0);
    endtask

    task automatic test_sequence();
        logic [19:0] want;
        apply_reset();
        step(1'b1, 5'd0, 20'h51230, 1'b0);
        step(1'b1, 5'd1, 20'h90050, 1'b0);
        step(1'b1, 5'd2, 20'hD0070, 1'b0);
        step(1'b1, 5'd3, 20'h00000, 1'b0);
        step(1'b0, 5'd0, 20'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            want = (i < 4) ? 20'h51230 : (i < 8) ? 20'h90050 : (i < 11) ? 20'hD0070 : 20'h00000;
            checks++;
            if (obs !== m_exp() || instr !== want || halted !== (i >= 11)) begin
                errors++;
                $display("FAIL sequence E%0d got=%h want=%h instr_want=%h", i, obs, m_exp(), want);
            end
            step(1'b0, 5'd0, 20'h0, i == 13);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] ep;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            w_we = 1'b1; w_addr = 2'(k); w_data = 20'h40A00 + 20'(k);
            @(posedge clk);
            #1;
        end
        w_we = 1'b0; w_start = 1'b1;
        @(posedge clk);
        #1 w_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ep = (c < 4) ? 2'd0 : 2'(((c - 4) / 3 + 1) % 4);
            checks++;
            if ({w_instr, w_pc, w_running, w_halted} !== {20'h40A00 + 20'(ep), ep, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL wrap cycle %0d got instr=%h pc=%0d run=%b halt=%b want pc=%0d",
                         c, w_instr, w_pc, w_running, w_halted, ep);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_abort();
        apply_reset();
        step(1'b0, 5'd0, 20'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 20'h0, 1'b0);
        #2 rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if (obs !== 27'h0) begin
            errors++;
            $display("FAIL abort_reset got=%h want=%h", obs, 27'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 20'h0, 1'b0);
            checks++;
            if (obs !== 27'h0) begin
                errors++;
                $display("FAIL abort_idle cycle %0d got=%h want=%h", i, obs, 27'h0);
            end
        end
        step(1'b0, 5'd0, 20'h0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (obs !== m_exp() || (i == 4 && instr !== 20'h90050) || (i == 11 && halted !== 1'b1)) begin
                errors++;
                $display("FAIL abort_replay E%0d got=%h want=%h", i, obs, m_exp());
            end
            step(1'b0, 5'd0, 20'h0, 1'b0);
        end
    endtask

    task automatic test_live_write();
        apply_reset();
        step(1'b1, 5'd3, 20'h00000, 1'b0);
        step(1'b1, 5'd4, 20'h00000, 1'b0);
        step(1'b0, 5'd0, 20'h0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (obs !== m_exp() || (i == 11 && {instr, pc} !== {20'h51000, 5'd3}) ||
                (i == 14 && {halted, pc} !== {1'b1, 5'd4})) begin
                errors++;
                $display("FAIL live_write E%0d got=%h want=%h", i, obs, m_exp());
            end
            step(i == 5, 5'd3, 20'h51000, i == 5 || i == 9);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        step(1'b1, 5'd1, 20'hAAAAA, 1'b0);
        step(1'b1, 5'd2, 20'h00000, 1'b0);
        for (int run = 0; run < 2; run++) begin
            step(1'b0, 5'd0, 20'h0, 1'b1);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (obs !== m_exp() ||
                    (i == 4 && instr !== ((run == 0) ? 20'hAAAAA : 20'h7BBBB))) begin
                    errors++;
                    $display("FAIL collision run %0d E%0d got=%h want=%h", run, i, obs, m_exp());
                end
                step(run == 0 && i == 3, 5'd1, 20'h7BBBB, 1'b0);
            end
            apply_reset();
        end
    endtask

    task automatic test_random();
        logic [19:0] w;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            for (int k = 0; k < 32; k++) begin
                w = 20'($urandom);
                w[19:18] = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                step(1'b1, 5'(k), w, 1'b0);
            end
            step(1'b0, 5'd0, 20'h0, 1'b1);
            for (int i = 0; i < 120; i++) begin
                checks++;
                if (obs !== m_exp()) begin
                    errors++;
                    $display("FAIL random it %0d cycle %0d got=%h want=%h", it, i, obs, m_exp());
                end
                w = 20'($urandom);
                w[19:18] = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                step($urandom_range(0, 4) == 0, 5'($urandom), w, $urandom_range(0, 3) == 0);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
        m_reset();
        test_reset();
        test_sequence();
        test_wrap();
        test_abort();
        test_live_write();
        test_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
